// File: rtl/packer_pkg.sv
// Shared types and helpers for the serial word packer and its unpack counterpart.
package packer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } packer_state_t;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2_w(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/word_out_reg.sv
// Single-entry holding register with valid/ready; a load and a drain may happen
// in the same cycle, in which case the new word replaces the drained one.
module word_out_reg #(
    parameter int W = 12
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain,
    output logic [W-1:0] data,
    output logic         valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_packer.sv
// Collects an LSB-first serial bit stream into WIDTH-bit words; in_last flushes
// a partial word with its unfilled upper bits cleared.
module serial_word_packer
    import packer_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = clog2_w(WIDTH + 1)
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    packer_state_t    state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             complete;
    logic             out_free;
    logic [WIDTH-1:0] word_next;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [CW-1:0]    load_count;
    logic [CW+WIDTH-1:0] out_word;

    assign in_ready  = (state == FILL);
    assign accept    = in_valid & in_ready;
    assign complete  = accept & (in_last | (cnt == CW'(WIDTH - 1)));
    // Bits above cnt are always zero in acc, so OR-ing in the new bit is enough.
    assign word_next = acc | (WIDTH'(in_bit) << cnt);
    assign out_free  = ~out_valid | out_ready;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        load       = 1'b0;
        load_data  = word_next;
        load_count = cnt + CW'(1);
        if (state == FILL) begin
            load = complete & out_free;
        end else begin
            load       = out_valid & out_ready;
            load_data  = acc;
            load_count = cnt;
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= FILL;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == FILL) begin
            if (complete) begin
                if (out_free) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    // Park the finished word; cnt now holds its bit count.
                    acc   <= word_next;
                    cnt   <= cnt + CW'(1);
                    state <= PEND;
                end
            end else if (accept) begin
                acc <= word_next;
                cnt <= cnt + CW'(1);
            end
        end else if (out_valid && out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            state <= FILL;
        end
    end

    word_out_reg #(
        .W(CW + WIDTH)
    ) u_out_reg (
        .CK       (CK),
        .RST      (RST),
        .load     (load),
        .load_data({load_count, load_data}),
        .drain    (out_ready),
        .data     (out_word),
        .valid    (out_valid)
    );

    assign out_count = out_word[CW+WIDTH-1:WIDTH];
    assign out_data  = out_word[WIDTH-1:0];

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed and random stimulus for serial_word_packer with a word scoreboard.
module tb_serial_word_packer;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CW-1:0]    count;
    } word_t;

    logic             CK;
    logic             RST;
    logic             in_bit;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             out_valid;
    logic             out_ready;

    int    n_checks;
    int    n_errors;
    int    n_words;
    int    stalls;
    word_t sb[$];

    serial_word_packer #(.WIDTH(WIDTH)) dut (
        .CK       (CK),
        .RST      (RST),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model and scoreboard, sampled on the falling edge.
    task automatic monitor();
        logic [WIDTH-1:0] m_acc;
        int               m_cnt;
        logic             prev_hold;
        logic [WIDTH-1:0] prev_data;
        logic [CW-1:0]    prev_count;
        word_t            w;
        m_acc     = '0;
        m_cnt     = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_count = '0;
        forever begin
            @(negedge CK);
            if (RST) begin
                m_acc     = '0;
                m_cnt     = 0;
                prev_hold = 1'b0;
                sb.delete();
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(prev_data));
                    chk("hold_count", 32'(out_count), 32'(prev_count));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_word", 32'(sb.size()), 32'd1);
                    end else begin
                        w = sb.pop_front();
                        chk("sb_data", 32'(out_data), 32'(w.data));
                        chk("sb_count", 32'(out_count), 32'(w.count));
                        n_words++;
                    end
                end
                if (in_valid && in_ready) begin
                    m_acc[m_cnt] = in_bit;
                    m_cnt++;
                    if (m_cnt == WIDTH || in_last) begin
                        w.data  = m_acc;
                        w.count = CW'(m_cnt);
                        sb.push_back(w);
                        m_acc = '0;
                        m_cnt = 0;
                    end
                end
                prev_hold  = out_valid && !out_ready;
                prev_data  = out_data;
                prev_count = out_count;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CK);
        #1;
    endtask

    // Presents a bit and returns 1 time unit after the edge that accepted it.
    task automatic send_bit(input logic b, input logic last);
        int waited;
        logic done;
        waited   = 0;
        done     = 1'b0;
        in_bit   = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!done && waited < 50) begin
            @(negedge CK);
            if (in_ready) done = 1'b1;
            cycle();
            waited++;
        end
        if (waited > 1) stalls++;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] v);
        for (int i = 0; i < WIDTH; i++) send_bit(v[i], 1'b0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bit   = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        int words0;
        n_checks  = 0;
        n_errors  = 0;
        n_words   = 0;
        stalls    = 0;
        RST       = 1'b1;
        out_ready = 1'b0;
        idle();
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) cycle();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        RST = 1'b0;
        cycle();

        // 1: full word, one-cycle valid pulse right after the 8th bit
        out_ready = 1'b1;
        pat = 8'b1000_1101;
        send_word(pat);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h8D);
        chk("t1_count", 32'(out_count), 32'd8);
        idle();
        cycle();
        chk("t1_valid_drop", 32'(out_valid), 32'd0);

        // 2: partial word flushed by in_last
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("t2_data", 32'(out_data), 32'h03);
        chk("t2_count", 32'(out_count), 32'd3);
        idle();
        cycle();

        // 3: back-pressure fills out register and accumulator
        out_ready = 1'b0;
        send_word(8'hFF);
        send_word(8'h00);
        chk("t3_in_ready_low", 32'(in_ready), 32'd0);
        chk("t3_held_data", 32'(out_data), 32'hFF);
        idle();
        repeat (3) cycle();
        chk("t3_still_held", 32'(out_data), 32'hFF);
        out_ready = 1'b1;
        cycle();
        chk("t3_second_valid", 32'(out_valid), 32'd1);
        chk("t3_second_data", 32'(out_data), 32'h00);
        chk("t3_in_ready_back", 32'(in_ready), 32'd1);
        cycle();
        chk("t3_drained", 32'(out_valid), 32'd0);

        // 4: 64-bit continuous stream, no stalls
        words0 = n_words;
        stalls = 0;
        for (int i = 0; i < 64; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        idle();
        repeat (3) cycle();
        chk("t4_stalls", 32'(stalls), 32'd0);
        chk("t4_words", 32'(n_words - words0), 32'd8);

        // 5: async reset mid-word while a word is held
        out_ready = 1'b0;
        send_word(8'hC3);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        idle();
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        RST = 1'b1;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_count", 32'(out_count), 32'd0);
        chk("t5_async_in_ready", 32'(in_ready), 32'd1);
        cycle();
        RST = 1'b0;
        out_ready = 1'b1;
        cycle();
        send_word(8'h5A);
        chk("t5_fresh_data", 32'(out_data), 32'h5A);
        chk("t5_fresh_count", 32'(out_count), 32'd8);
        idle();
        cycle();

        // 6: random traffic
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_bit    = 1'($urandom_range(0, 1));
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        idle();
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        idle();
        repeat (4) cycle();
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        chk("t6_idle_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
